// File: rtl/memory_access_stage_if.sv
// Data RAM bus between the DLX MEM stage (master) and the data memory (slave).
// The request side is held stable from req rising until the cycle ack is seen.
interface memory_access_stage_if #(
  parameter int N = 32
);
  logic         req;
  logic         we;
  logic [N-1:0] addr;
  logic [3:0]   be;
  logic [N-1:0] wdata;
  logic [N-1:0] rdata;
  logic         ack;

  modport master (
    output req,
    output we,
    output addr,
    output be,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  be,
    input  wdata,
    output rdata,
    output ack
  );
endinterface

// File: rtl/memory_access_stage.sv
// DLX MEM stage: data RAM loads/stores over a req/ack bus, load alignment, MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into 1-cycle traps.
module memory_access_stage #(
  parameter int N     = 32,
  parameter int RF_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [1:0]           mem_size,
  input  logic                 load_unsigned,
  input  logic [N-1:0]         alu_result,
  input  logic [N-1:0]         store_data,
  input  logic [RF_AW-1:0]     rd_in,
  input  logic                 rf_we_in,
  output logic                 stall,
  memory_access_stage_if.master dmem,
  output logic                 valid_out,
  output logic [N-1:0]         data_from_memory,
  output logic [N-1:0]         data_from_alu,
  output logic                 select_wb,
  output logic [RF_AW-1:0]     rd_out,
  output logic                 rf_we_out,
  output logic                 misaligned
);

  if (N != 32) begin : g_bad_width
    $error("memory_access_stage: N must be 32");
  end

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state;
  state_t state_next;

  logic              mem_op;
  logic              misalign_in;
  logic              trap;
  logic              start;
  logic [3:0]        be_in;
  logic [N-1:0]      wdata_in;

  logic [N-1:0]      addr_q;
  logic [3:0]        be_q;
  logic [N-1:0]      wdata_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic              uns_q;
  logic [RF_AW-1:0]  rd_q;
  logic              rf_we_q;
  logic [N-1:0]      alu_q;
  logic              misaligned_q;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [N-1:0]      load_ext;

  assign mem_op = valid_in & (is_load | is_store);

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign_in = 1'b0;
    case (mem_size)
      2'b00:   misalign_in = 1'b0;
      2'b01:   misalign_in = alu_result[0];
      default: misalign_in = |alu_result[1:0];
    endcase
  end
`else
  assign misalign_in = 1'b0;
`endif

  assign trap  = mem_op & misalign_in;
  assign start = mem_op & ~misalign_in;

  // Half and word accesses ignore the low address bits, so they align down.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = store_data;
    case (mem_size)
      2'b00: begin
        be_in    = 4'b0001 << alu_result[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_in    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{store_data[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = store_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        stall = ~dmem.ack;
        if (dmem.ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      stall = 1'b0;
    end
  end

  assign dmem.req   = (state == ACCESS);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

  // Everything the access and write-back need is frozen here so upstream may change freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      rf_we_q <= 1'b0;
      alu_q   <= '0;
    end else if (state == IDLE && start) begin
      addr_q  <= {alu_result[N-1:2], 2'b00};
      be_q    <= be_in;
      wdata_q <= wdata_in;
      we_q    <= is_store;
      size_q  <= mem_size;
      lane_q  <= alu_result[1:0];
      uns_q   <= load_unsigned;
      rd_q    <= rd_in;
      rf_we_q <= rf_we_in;
      alu_q   <= alu_result;
    end
  end

  always_comb begin
    byte_sel = dmem.rdata[7:0];
    case (lane_q)
      2'd0:    byte_sel = dmem.rdata[7:0];
      2'd1:    byte_sel = dmem.rdata[15:8];
      2'd2:    byte_sel = dmem.rdata[23:16];
      default: byte_sel = dmem.rdata[31:24];
    endcase
    half_sel = lane_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{(N-8){~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{(N-16){~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = dmem.rdata;
    endcase
  end

  // MEM/WB register: loads straight through in IDLE, or from the frozen copy on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out        <= 1'b0;
      data_from_memory <= '0;
      data_from_alu    <= '0;
      select_wb        <= 1'b0;
      rd_out           <= '0;
      rf_we_out        <= 1'b0;
      misaligned_q     <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            valid_out <= 1'b0;
          end else begin
            valid_out        <= valid_in;
            data_from_memory <= '0;
            data_from_alu    <= alu_result;
            select_wb        <= 1'b1;
            rd_out           <= rd_in;
            rf_we_out        <= valid_in & rf_we_in & ~trap;
            misaligned_q     <= trap;
          end
        end
        ACCESS: begin
          if (dmem.ack) begin
            valid_out        <= 1'b1;
            data_from_memory <= we_q ? '0 : load_ext;
            data_from_alu    <= alu_q;
            select_wb        <= we_q;
            rd_out           <= rd_q;
            rf_we_out        <= ~we_q & rf_we_q;
          end else begin
            valid_out <= 1'b0;
          end
        end
        default: valid_out <= 1'b0;
      endcase
    end
  end

  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed cases, then random traffic
// against an arithmetic reference model of alignment, lanes and extension.
module tb_memory_access_stage;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        is_load;
  logic        is_store;
  logic [1:0]  mem_size;
  logic        load_unsigned;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        rf_we_in;
  logic        stall;
  logic        valid_out;
  logic [31:0] data_from_memory;
  logic [31:0] data_from_alu;
  logic        select_wb;
  logic [4:0]  rd_out;
  logic        rf_we_out;
  logic        misaligned;

  int tests_run;
  int tests_failed;

  memory_access_stage_if #(.N(32)) dmem_bus ();

  memory_access_stage #(.N(32), .RF_AW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .is_load          (is_load),
    .is_store         (is_store),
    .mem_size         (mem_size),
    .load_unsigned    (load_unsigned),
    .alu_result       (alu_result),
    .store_data       (store_data),
    .rd_in            (rd_in),
    .rf_we_in         (rf_we_in),
    .stall            (stall),
    .dmem             (dmem_bus.master),
    .valid_out        (valid_out),
    .data_from_memory (data_from_memory),
    .data_from_alu    (data_from_alu),
    .select_wb        (select_wb),
    .rd_out           (rd_out),
    .rf_we_out        (rf_we_out),
    .misaligned       (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (addr % 2) != 0;
    return (addr % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 4'(1 << (addr % 4));
    if (size == 2'd1) return 4'(3 << (((addr / 2) % 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] sdata);
    if (size == 2'd0) return (sdata & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (sdata & 32'hFFFF) * 32'h0001_0001;
    return sdata;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                             input logic [31:0] rdata, input bit uns);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rdata >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Runs one instruction from issue to the valid_out pulse, playing the RAM as well.
  task automatic apply_stimulus(input bit ld, input bit st, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input int waits,
                                input logic [4:0] rd, input bit rfwe);
    bit mem;
    bit trap;
    int stalls;
    mem           = ld | st;
    trap          = mem && model_misaligned(size, addr);
    valid_in      = 1'b1;
    is_load       = ld;
    is_store      = st;
    mem_size      = size;
    load_unsigned = uns;
    alu_result    = addr;
    store_data    = sdata;
    rd_in         = rd;
    rf_we_in      = rfwe;
    #1;
    stalls = 0;
    if (mem && !trap) begin
      if (stall) stalls++;
      @(posedge clk); #1;
      check_output("req", 32'(dmem_bus.req), 32'd1);
      check_output("addr", dmem_bus.addr, addr & ~32'h3);
      check_output("be", 32'(dmem_bus.be), 32'(model_be(size, addr)));
      check_output("we", 32'(dmem_bus.we), 32'(st));
      if (st) check_output("wdata", dmem_bus.wdata, model_wdata(size, sdata));
      for (int w = 0; w < waits; w++) begin
        if (stall) stalls++;
        @(posedge clk); #1;
      end
      check_output("req_held", 32'(dmem_bus.req), 32'd1);
      check_output("addr_held", dmem_bus.addr, addr & ~32'h3);
      dmem_bus.ack   = 1'b1;
      dmem_bus.rdata = rdata;
      #1;
      if (stall) stalls++;
      check_output("stall_cycles", 32'(stalls), 32'(waits + 1));
      @(posedge clk); #1;
      dmem_bus.ack   = 1'b0;
      dmem_bus.rdata = $urandom;
    end else begin
      check_output("stall_nomem", 32'(stall), 32'd0);
      check_output("req_nomem", 32'(dmem_bus.req), 32'd0);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    check_output("valid_out", 32'(valid_out), 32'd1);
    check_output("data_from_alu", data_from_alu, addr);
    check_output("select_wb", 32'(select_wb), 32'(!(ld && !trap)));
    check_output("rd_out", 32'(rd_out), 32'(rd));
    check_output("rf_we_out", 32'(rf_we_out), 32'(rfwe && !st && !trap));
    check_output("misaligned", 32'(misaligned), 32'(trap));
    if (ld && !trap) check_output("load_data", data_from_memory, model_load(size, addr, rdata, uns));
    if (trap) check_output("trap_data", data_from_memory, 32'd0);
    @(posedge clk); #1;
    check_output("valid_pulse", 32'(valid_out), 32'd0);
    check_output("misaligned_pulse", 32'(misaligned), 32'd0);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    valid_in       = 1'b0;
    is_load        = 1'b0;
    is_store       = 1'b0;
    mem_size       = 2'b00;
    load_unsigned  = 1'b0;
    alu_result     = 32'h0;
    store_data     = 32'h0;
    rd_in          = 5'd0;
    rf_we_in       = 1'b0;
    dmem_bus.rdata = 32'h0;
    dmem_bus.ack   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid_out", 32'(valid_out), 32'd0);
    check_output("rst_req", 32'(dmem_bus.req), 32'd0);
    check_output("rst_stall", 32'(stall), 32'd0);
    check_output("rst_alu", data_from_alu, 32'd0);
    check_output("rst_rf_we", 32'(rf_we_out), 32'd0);
    check_output("rst_misaligned", 32'(misaligned), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    apply_stimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 0, 5'd3, 1'b1);
    apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 3, 5'd7, 1'b1);
    check_output("lb_result", data_from_alu, 32'h0000_0103);
    apply_stimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 0, 5'd9, 1'b1);
    apply_stimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h1234_8001, 1, 5'd4, 1'b1);
    apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0106, 32'h0, 32'hCAFE_F00D, 2, 5'd5, 1'b1);

    // Reset while an access is outstanding, followed by a late ack.
    valid_in   = 1'b1;
    is_load    = 1'b1;
    is_store   = 1'b0;
    mem_size   = 2'b10;
    alu_result = 32'h0000_0400;
    rd_in      = 5'd2;
    rf_we_in   = 1'b1;
    @(posedge clk); #1;
    check_output("pre_rst_req", 32'(dmem_bus.req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    valid_in = 1'b0;
    #1;
    check_output("post_rst_req", 32'(dmem_bus.req), 32'd0);
    check_output("post_rst_stall", 32'(stall), 32'd0);
    check_output("post_rst_valid", 32'(valid_out), 32'd0);
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_bus.ack = 1'b0;
    check_output("late_ack_valid", 32'(valid_out), 32'd0);
    check_output("late_ack_req", 32'(dmem_bus.req), 32'd0);

    for (int i = 0; i < 60; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      apply_stimulus(op == 1, op == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
